alarm_key_controller: RTL and testbench
=======================================

# alarm_key_controller

Sequencing controller for the alarm clock's key-entry path. It captures keypad digits into a four-digit shift buffer with an AM/PM flag. On a button edge it commits the buffer to the alarm register (`load_new_a`) or the time counter (`load_new_c`), and it drives the display-select flags. It sits between the keypad decoder and the alarm register / time counter, and it is the only source of their load strobes.

## Interface
- `TIMEOUT_TICKS`, default 10: number of `one_second` ticks without a key before entry is abandoned (1..255).
- `clock` input 1: system clock; all logic is on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `one_second` input 1: one-cycle tick pulse, once per second.
- `key_valid` input 1: one-cycle strobe; `key` is valid when high.
- `key` input 4: decimal digit 0..9. Values 10..15 are ignored.
- `am_pm_key` input 1: one-cycle strobe that toggles the buffer AM flag.
- `alarm_button` input 1: level, synchronous. Rising edge commits to the alarm register; held in IDLE, it shows the alarm.
- `time_button` input 1: level, synchronous. Rising edge commits to the time counter.
- `key_buffer_ls_min`, `key_buffer_ms_min`, `key_buffer_ls_hr`, `key_buffer_ms_hr` output 4 each: buffered digits.
- `key_buffer_AM` output 1: buffered AM flag.
- `load_new_a` output 1: one-cycle alarm-register load strobe.
- `load_new_c` output 1: one-cycle time-counter load strobe.
- `show_alarm` output 1: display selects the alarm value.
- `show_new_time` output 1: display selects the key buffer.
- `entry_error` output 1: one-cycle pulse when a commit is rejected.

## Operation
- States: IDLE, SHOW_ALARM, ENTRY, COMMIT_A, COMMIT_T, CLEAR.
- Internal registers:
  - previous-value registers for `alarm_button` and `time_button`, used for edge detection;
  - a digit count (0..4, saturating);
  - a tick counter.
- Digit shift: a valid digit in IDLE or ENTRY shifts the buffer:
  - `ms_hr`←`ls_hr`, `ls_hr`←`ms_min`, `ms_min`←`ls_min`, `ls_min`←`key`;
  - the digit count increments (saturating), the tick counter clears, and the state becomes ENTRY;
  - a fifth digit drops the oldest.
- `am_pm_key` in IDLE or ENTRY toggles `key_buffer_AM` and enters ENTRY.
- ENTRY exits:
  - alarm rising edge → COMMIT_A;
  - time rising edge → COMMIT_T;
  - tick counter reaching `TIMEOUT_TICKS` → CLEAR, with no load.
- COMMIT_A: `load_new_a`=1 for exactly one cycle, then CLEAR. COMMIT_T does the same with `load_new_c`.
- CLEAR: buffer, AM flag, digit count and tick counter go to 0, then IDLE.
- IDLE with `alarm_button` high → SHOW_ALARM. Release → IDLE. Keys, AM/PM strobes and `time_button` are ignored in SHOW_ALARM.
- Button edges in IDLE do nothing; commit happens only from ENTRY.
- Display flags:
  - `show_new_time`=1 in ENTRY, COMMIT_A and COMMIT_T;
  - `show_alarm`=1 only in SHOW_ALARM.
- Simultaneous events, by priority:
  - a button edge beats `key_valid`/`am_pm_key` in the same cycle, and the key is discarded;
  - an alarm edge beats a time edge;
  - a key in the same cycle as the timeout tick is accepted, and the timeout is cancelled.

## Timing
- Reset (`reset_n`=0 at a clock edge): every output 0, state IDLE, all internal registers 0. Reset mid-commit suppresses any pending strobe.
- Latency from a digit strobe in cycle N: the buffer shows the digit in cycle N+1.
- Latency from a button edge sampled in cycle N:
  - the load strobe is high in cycle N+1;
  - the buffer stays stable through N+1;
  - the buffer is zero from N+3 (CLEAR in N+2).
- All outputs are registered; none is combinational from the inputs.
- Timeout: CLEAR is entered the cycle after the `TIMEOUT_TICKS`-th tick since the last key.

## Configuration
- `ENTRY_CHECK_EN` defined:
  - before COMMIT_A or COMMIT_T, hours must be 01..12 (`ms_hr`≤1; `ms_hr`=1 implies `ls_hr`≤2; hours≠00) and `ms_min` must be ≤5;
  - a failing check pulses `entry_error` for one cycle, goes to CLEAR, and issues no load.
- `ENTRY_CHECK_EN` undefined: no checking; `entry_error` is tied to 0.

## Structure
- Shared package `alarm_clock_pkg`:
  - state enum;
  - digit width constant (4);
  - max-hour and max-minute-tens constants;
  - default timeout.
- Sub-module `key_shift_buffer`: the four digit registers plus the AM flag, with shift, toggle and clear controls.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles → all outputs 0; then idle 5 cycles → no strobes.
- Alarm commit: keys 1,1,4,5, then `am_pm_key`, then `alarm_button` rising → one-cycle `load_new_a` with `ms_hr`/`ls_hr`/`ms_min`/`ls_min` = 1/1/4/5 and AM=1; buffer 0 two cycles later.
- Time commit with short entry: keys 7,3,0, then `time_button` → `load_new_c` with digits 0,7,3,0; `load_new_a` stays 0.
- Timeout: key 1, then 10 `one_second` ticks with no key → CLEAR, buffer 0, `show_new_time` 0, no load. Variant: a key on the 10th tick keeps ENTRY.
- Validation: keys 1,3,0,0 then alarm edge:
  - with `ENTRY_CHECK_EN` → `entry_error` pulse, no `load_new_a`;
  - without it → `load_new_a` with 1,3,0,0.
- Show alarm: `alarm_button` held 20 cycles in IDLE with a key 5 during the hold → `show_alarm`=1, buffer unchanged; release → `show_alarm`=0 next cycle.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock key-entry path.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ALARM,
    ST_ENTRY,
    ST_COMMIT_A,
    ST_COMMIT_T,
    ST_CLEAR
  } state_t;

  localparam int DIGIT_W         = 4;
  localparam int MAX_HOUR        = 12;
  localparam int MAX_MIN_TENS    = 5;
  localparam int DEFAULT_TIMEOUT = 10;

  // True when the buffered digits form a 12-hour time 01:00..12:59.
  function automatic logic entry_valid(input logic [DIGIT_W-1:0] ms_hr,
                                       input logic [DIGIT_W-1:0] ls_hr,
                                       input logic [DIGIT_W-1:0] ms_min);
    logic [7:0] hours;
    hours = 8'(ms_hr) * 8'd10 + 8'(ls_hr);
    return (ms_hr <= 4'd1) && (hours >= 8'd1) && (hours <= 8'(MAX_HOUR)) &&
           (ms_min <= 4'(MAX_MIN_TENS));
  endfunction

endpackage

// File: rtl/key_shift_buffer.sv
// Four-digit key shift buffer plus AM flag; clear wins over shift/toggle.
module key_shift_buffer
  import alarm_clock_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               shift,
  input  logic               toggle_am,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] key,
  output logic [DIGIT_W-1:0] ls_min,
  output logic [DIGIT_W-1:0] ms_min,
  output logic [DIGIT_W-1:0] ls_hr,
  output logic [DIGIT_W-1:0] ms_hr,
  output logic               am
);

  // Shift new digit in at ls_min, oldest digit falls off ms_hr.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      ls_min <= '0;
      ms_min <= '0;
      ls_hr  <= '0;
      ms_hr  <= '0;
      am     <= 1'b0;
    end else begin
      if (shift) begin
        ms_hr  <= ls_hr;
        ls_hr  <= ms_min;
        ms_min <= ls_min;
        ls_min <= key;
      end
      if (toggle_am) am <= ~am;
    end
  end

endmodule

// File: rtl/alarm_key_controller.sv
// Key-entry sequencer: collects digits, commits them to the alarm register or
// time counter on a button edge, and drives the display-select flags.
// Optional macro ENTRY_CHECK_EN rejects commits that are not a valid 12-hour time.
module alarm_key_controller
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               one_second,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key,
  input  logic               am_pm_key,
  input  logic               alarm_button,
  input  logic               time_button,
  output logic [DIGIT_W-1:0] key_buffer_ls_min,
  output logic [DIGIT_W-1:0] key_buffer_ms_min,
  output logic [DIGIT_W-1:0] key_buffer_ls_hr,
  output logic [DIGIT_W-1:0] key_buffer_ms_hr,
  output logic               key_buffer_AM,
  output logic               load_new_a,
  output logic               load_new_c,
  output logic               show_alarm,
  output logic               show_new_time,
  output logic               entry_error
);

  state_t     state;
  logic       alarm_prev, time_prev;
  logic [2:0] digit_cnt;
  logic [7:0] tick_cnt;

  logic alarm_edge, time_edge, digit_ok, accepting;
  logic timeout_now, do_shift, do_toggle, do_clear, check_ok;

  // Event decode; button edges (and alarm level in IDLE) pre-empt keys.
  always_comb begin
    alarm_edge  = alarm_button & ~alarm_prev;
    time_edge   = time_button & ~time_prev;
    digit_ok    = key_valid & (key <= 4'd9);
    accepting   = ((state == ST_IDLE) & ~alarm_button & ~time_edge) |
                  ((state == ST_ENTRY) & ~alarm_edge & ~time_edge);
    timeout_now = (state == ST_ENTRY) & one_second & ~digit_ok & ~alarm_edge &
                  ~time_edge & (tick_cnt == 8'(TIMEOUT_TICKS - 1));
    do_shift    = accepting & digit_ok;
    do_toggle   = accepting & am_pm_key & ~timeout_now;
    do_clear    = (state == ST_CLEAR);
`ifdef ENTRY_CHECK_EN
    check_ok    = entry_valid(key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min);
`else
    check_ok    = 1'b1;
`endif
  end

  key_shift_buffer u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift     (do_shift),
    .toggle_am (do_toggle),
    .clear     (do_clear),
    .key       (key),
    .ls_min    (key_buffer_ls_min),
    .ms_min    (key_buffer_ms_min),
    .ls_hr     (key_buffer_ls_hr),
    .ms_hr     (key_buffer_ms_hr),
    .am        (key_buffer_AM)
  );

  // Sequencer with registered strobes and display flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      alarm_prev    <= 1'b0;
      time_prev     <= 1'b0;
      digit_cnt     <= '0;
      tick_cnt      <= '0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      show_alarm    <= 1'b0;
      show_new_time <= 1'b0;
      entry_error   <= 1'b0;
    end else begin
      alarm_prev  <= alarm_button;
      time_prev   <= time_button;
      load_new_a  <= 1'b0;
      load_new_c  <= 1'b0;
      entry_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (alarm_button) begin
            state      <= ST_SHOW_ALARM;
            show_alarm <= 1'b1;
          end else if (do_shift || do_toggle) begin
            state         <= ST_ENTRY;
            show_new_time <= 1'b1;
          end
          if (do_shift) begin
            digit_cnt <= (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
            tick_cnt  <= '0;
          end
        end
        ST_ENTRY: begin
          if (alarm_edge || time_edge) begin
            if (check_ok) begin
              state      <= alarm_edge ? ST_COMMIT_A : ST_COMMIT_T;
              load_new_a <= alarm_edge;
              load_new_c <= ~alarm_edge;
            end else begin
              state         <= ST_CLEAR;
              entry_error   <= 1'b1;
              show_new_time <= 1'b0;
            end
          end else if (do_shift) begin
            digit_cnt <= (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
            tick_cnt  <= '0;
          end else if (timeout_now) begin
            state         <= ST_CLEAR;
            show_new_time <= 1'b0;
          end else if (one_second) begin
            tick_cnt <= tick_cnt + 8'd1;
          end
        end
        ST_SHOW_ALARM: begin
          if (!alarm_button) begin
            state      <= ST_IDLE;
            show_alarm <= 1'b0;
          end
        end
        ST_COMMIT_A, ST_COMMIT_T: begin
          state         <= ST_CLEAR;
          show_new_time <= 1'b0;
        end
        ST_CLEAR: begin
          state     <= ST_IDLE;
          digit_cnt <= '0;
          tick_cnt  <= '0;
        end
        default: begin
          state         <= ST_IDLE;
          show_alarm    <= 1'b0;
          show_new_time <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_key_controller.sv
// Directed bench for alarm_key_controller with a cycle-level behavioural model.
module tb_alarm_key_controller;
  localparam int TO = 10;

  logic clock = 1'b0, reset_n = 1'b0, one_second = 1'b0, key_valid = 1'b0;
  logic am_pm_key = 1'b0, alarm_button = 1'b0, time_button = 1'b0;
  logic [3:0] key = 4'd0;
  logic [3:0] b_ls_min, b_ms_min, b_ls_hr, b_ms_hr;
  logic b_am, load_a, load_c, show_a, show_t, err;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  alarm_key_controller #(.TIMEOUT_TICKS(TO)) dut (
    .clock(clock), .reset_n(reset_n), .one_second(one_second),
    .key_valid(key_valid), .key(key), .am_pm_key(am_pm_key),
    .alarm_button(alarm_button), .time_button(time_button),
    .key_buffer_ls_min(b_ls_min), .key_buffer_ms_min(b_ms_min),
    .key_buffer_ls_hr(b_ls_hr), .key_buffer_ms_hr(b_ms_hr),
    .key_buffer_AM(b_am), .load_new_a(load_a), .load_new_c(load_c),
    .show_alarm(show_a), .show_new_time(show_t), .entry_error(err)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_SHOW = 1, P_ENTRY = 2, P_STROBE = 3, P_WIPE = 4;
  int m_dig[4];           // [0]=ls_min .. [3]=ms_hr
  bit m_am, m_la, m_lc, m_err, m_valid, m_aprev, m_tprev;
  int m_phase, m_ticks;

  function automatic bit time_ok();
`ifdef ENTRY_CHECK_EN
    int hours;
    hours = m_dig[3] * 10 + m_dig[2];
    return (hours >= 1) && (hours <= 12) && (m_dig[1] <= 5);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step();
    bit ae, te, dig, timed_out;
    if (!reset_n) begin
      m_dig = '{0, 0, 0, 0};
      m_am = 0; m_la = 0; m_lc = 0; m_err = 0;
      m_aprev = 0; m_tprev = 0; m_ticks = 0;
      m_phase = P_IDLE; m_valid = 1;
      return;
    end
    ae  = alarm_button && !m_aprev;
    te  = time_button && !m_tprev;
    dig = key_valid && (key <= 4'd9);
    m_aprev = alarm_button; m_tprev = time_button;
    m_la = 0; m_lc = 0; m_err = 0; timed_out = 0;
    case (m_phase)
      P_STROBE: m_phase = P_WIPE;
      P_WIPE: begin
        m_dig = '{0, 0, 0, 0}; m_am = 0; m_ticks = 0; m_phase = P_IDLE;
      end
      P_SHOW: if (!alarm_button) m_phase = P_IDLE;
      default: begin
        if (m_phase == P_IDLE && alarm_button) m_phase = P_SHOW;
        else if (m_phase == P_ENTRY && (ae || te)) begin
          if (time_ok()) begin
            if (ae) m_la = 1; else m_lc = 1;
            m_phase = P_STROBE;
          end else begin
            m_err = 1; m_phase = P_WIPE;
          end
        end else if (m_phase == P_IDLE && te) begin
        end else begin
          if (dig) begin
            m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0];
            m_dig[0] = int'(key); m_ticks = 0;
          end else if (m_phase == P_ENTRY && one_second) begin
            m_ticks++;
            timed_out = (m_ticks >= TO);
          end
          if (timed_out) m_phase = P_WIPE;
          else begin
            if (am_pm_key) m_am = !m_am;
            if (dig || am_pm_key) m_phase = P_ENTRY;
          end
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Continuous comparison against the model.
  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      chk("m_buf", {b_ms_hr, b_ls_hr, b_ms_min, b_ls_min},
          {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])});
      chk("m_am", b_am, m_am);
      chk("m_load_a", load_a, m_la);
      chk("m_load_c", load_c, m_lc);
      chk("m_err", err, m_err);
      chk("m_show_alarm", show_a, m_phase == P_SHOW);
      chk("m_show_new_time", show_t, (m_phase == P_ENTRY) || (m_phase == P_STROBE));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic press(int d);
    key = 4'(d); key_valid = 1; cyc(); key_valid = 0; key = 0;
  endtask

  task automatic tick();
    one_second = 1; cyc(); one_second = 0; cyc(2);
  endtask

  function automatic logic [15:0] bufv();
    return {b_ms_hr, b_ls_hr, b_ms_min, b_ls_min};
  endfunction

  initial begin
    // reset
    cyc(2);
    chk("rst_buf", bufv(), 16'h0);
    chk("rst_flags", {b_am, load_a, load_c, show_a, show_t, err}, 6'b0);
    reset_n = 1;
    cyc(5);
    chk("idle_strobes", {load_a, load_c, err}, 3'b0);

    // alarm commit 11:45 AM
    press(1); press(1); press(4); press(5);
    am_pm_key = 1; cyc(); am_pm_key = 0;
    alarm_button = 1; cyc();
    chk("a_load", load_a, 1'b1);
    chk("a_buf", bufv(), 16'h1145);
    chk("a_am", b_am, 1'b1);
    alarm_button = 0; cyc();
    chk("a_load_once", load_a, 1'b0);
    chk("a_buf_clear_cycle", bufv(), 16'h1145);
    cyc();
    chk("a_buf_zero", {b_am, bufv()}, 17'h0);

    // time commit with three digits
    press(7); press(3); press(0);
    time_button = 1; cyc();
    chk("t_load_c", load_c, 1'b1);
    chk("t_load_a", load_a, 1'b0);
    chk("t_buf", bufv(), 16'h0730);
    time_button = 0; cyc(3);

    // timeout
    press(1);
    repeat (TO - 1) tick();
    chk("to_still_entry", show_t, 1'b1);
    one_second = 1; cyc(); one_second = 0;
    chk("to_exit", show_t, 1'b0);
    cyc();
    chk("to_buf_zero", bufv(), 16'h0);

    // key on the final tick cancels the timeout
    press(1);
    repeat (TO - 1) tick();
    one_second = 1; key = 2; key_valid = 1; cyc();
    one_second = 0; key_valid = 0; key = 0;
    cyc(3);
    chk("to_cancel_entry", show_t, 1'b1);
    chk("to_cancel_buf", bufv(), 16'h0012);
    repeat (TO) tick();
    chk("to2_buf_zero", bufv(), 16'h0);

    // validation of 13:00
    press(1); press(3); press(0); press(0);
    alarm_button = 1; cyc();
`ifdef ENTRY_CHECK_EN
    chk("v_err", err, 1'b1);
    chk("v_no_load", load_a, 1'b0);
`else
    chk("v_load", load_a, 1'b1);
    chk("v_buf", bufv(), 16'h1300);
`endif
    alarm_button = 0; cyc(3);

    // out-of-range key ignored in IDLE
    key = 4'd12; key_valid = 1; cyc(); key_valid = 0; key = 0;
    chk("bad_key_idle", show_t, 1'b0);
    chk("bad_key_buf", bufv(), 16'h0);

    // fifth digit drops oldest; simultaneous edges and key
    press(1); press(1); press(2); press(3); press(4);
    chk("five_digits", bufv(), 16'h1234);
    alarm_button = 1; time_button = 1; key = 9; key_valid = 1; cyc();
    key_valid = 0; key = 0;
    chk("prio_load_a", load_a, 1'b1);
    chk("prio_load_c", load_c, 1'b0);
    chk("prio_key_dropped", bufv(), 16'h1234);
    alarm_button = 0; time_button = 0; cyc(3);

    // reset together with the commit edge suppresses the strobe
    press(1); press(0); press(0); press(0);
    alarm_button = 1; reset_n = 0; cyc();
    chk("rst_commit_load", load_a, 1'b0);
    chk("rst_commit_buf", bufv(), 16'h0);
    reset_n = 1; alarm_button = 0; cyc(2);

    // show alarm while held, keys ignored
    alarm_button = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin key = 5; key_valid = 1; end
      else begin key = 0; key_valid = 0; end
      cyc();
    end
    key_valid = 0; key = 0;
    chk("show_alarm_on", show_a, 1'b1);
    chk("show_buf", bufv(), 16'h0);
    chk("show_no_entry", show_t, 1'b0);
    alarm_button = 0; cyc();
    chk("show_alarm_off", show_a, 1'b0);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
